mips_ras: RTL

Parametrised return-address stack for the MIPS single-cycle core. Captures the link address on every JAL/JALR and supplies a predicted target for the next JR $ra. It sits beside the PC logic in the datapath, fed by the control unit's decoded jump signals. It generalises the fixed single-level $ra link into a DEPTH-deep circular stack with overflow wrap, underflow reporting and an optional prediction checker.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/mips_ras_mem.sv | 34 +++
 rtl/mips_ras.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants and types for the MIPS single-cycle core.
// Holds the datapath address width, the link register index used by
// JAL/JR $ra, the default return-address-stack depth, and the
// operation encoding used by the return-address stack.
package mips_pkg;

    localparam int          ADDR_W    = 32;
    localparam logic [4:0]  RA_REG    = 5'd31;
    localparam int          RAS_DEPTH = 8;

    // Stack operation for one cycle, built as {pop, push}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_TAIL = 2'b11
    } ras_op_e;

    // Combine the retiring jump strobes into a stack operation.
    function automatic ras_op_e ras_decode(input logic i_push, input logic i_pop);
        return ras_op_e'({i_pop, i_push});
    endfunction

endpackage

// File: rtl/mips_ras_mem.sv
// mips_ras_mem
// DEPTH x AW register array backing the return-address stack.
// Ports:
//   clk      in   clock; writes happen on the rising edge
//   i_we     in   write enable
//   i_waddr  in   write index
//   i_wdata  in   value written at i_waddr
//   i_raddr  in   read index
//   o_rdata  out  asynchronous read of entry i_raddr
module mips_ras_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [AW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [AW-1:0]            o_rdata
);

    logic [AW-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset: occupancy is tracked by the
    // count in the parent, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_ras.sv
// mips_ras
// Return-address stack for the MIPS single-cycle core. Captures the link
// address on every JAL/JALR and predicts the target of the next JR $ra.
// Circular storage: a push beyond DEPTH overwrites the oldest entry.
// Optional prediction checker enabled by the macro MIPS_RAS_CHECK_EN.
// Ports:
//   clk             in   clock
//   reset           in   asynchronous active-low reset
//   flush           in   synchronous clear of pointer and count
//   push/push_addr  in   JAL/JALR retiring and its link address
//   pop             in   JR $31 retiring
//   jr_target       in   resolved JR target (checker only)
//   top_valid       out  stack non-empty
//   top_addr        out  predicted return address, 0 when empty
//   count           out  occupancy 0..DEPTH
//   overflow        out  pulse: oldest entry overwritten
//   underflow       out  pulse: pop on empty stack
//   mispredict      out  pulse: popped prediction was wrong
//   mispredict_cnt  out  saturating mispredict count
module mips_ras
    import mips_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = ADDR_W,
    parameter int CW    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [AW-1:0]          push_addr,
    input  logic                   pop,
    input  logic [AW-1:0]          jr_target,
    output logic                   top_valid,
    output logic [AW-1:0]          top_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   mispredict,
    output logic [CW-1:0]          mispredict_cnt
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    logic [PW-1:0]   r_tp;
    logic [CNTW-1:0] r_count;
    logic            r_overflow;
    logic            r_underflow;

    logic [PW-1:0]   w_tp_next;
    logic [CNTW-1:0] w_count_next;
    logic            w_ovf_next;
    logic            w_udf_next;
    logic            w_we;
    logic [PW-1:0]   w_waddr;
    logic [AW-1:0]   w_rdata;
    logic            w_empty;
    ras_op_e         w_op;

    assign w_op    = ras_decode(push, pop);
    assign w_empty = (r_count == '0);

    mips_ras_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (push_addr),
        .i_raddr (r_tp),
        .o_rdata (w_rdata)
    );

    // Tail call on a non-empty stack replaces the top in place; on an
    // empty stack it degenerates to a plain push that also flags underflow.
    // A full push still advances tp, which drops the oldest entry.
    always_comb begin
        w_tp_next    = r_tp;
        w_count_next = r_count;
        w_ovf_next   = 1'b0;
        w_udf_next   = 1'b0;
        w_we         = 1'b0;
        w_waddr      = r_tp + 1'b1;
        if (flush) begin
            w_tp_next    = '0;
            w_count_next = '0;
        end else begin
            case (w_op)
                OP_PUSH: begin
                    w_we      = 1'b1;
                    w_tp_next = r_tp + 1'b1;
                    if (r_count == FULL) begin
                        w_ovf_next = 1'b1;
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        w_udf_next = 1'b1;
                    end else begin
                        w_tp_next    = r_tp - 1'b1;
                        w_count_next = r_count - 1'b1;
                    end
                end
                OP_TAIL: begin
                    w_we = 1'b1;
                    if (w_empty) begin
                        w_udf_next   = 1'b1;
                        w_tp_next    = r_tp + 1'b1;
                        w_count_next = r_count + 1'b1;
                    end else begin
                        w_waddr = r_tp;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_tp        <= w_tp_next;
            r_count     <= w_count_next;
            r_overflow  <= w_ovf_next;
            r_underflow <= w_udf_next;
        end
    end

    assign top_valid = !w_empty;
    assign top_addr  = w_empty ? '0 : w_rdata;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

`ifdef MIPS_RAS_CHECK_EN
    logic          r_mispredict;
    logic [CW-1:0] r_mcnt;
    logic          w_miss;

    // Every pop is judged against the resolved target; a pop with nothing
    // to predict is always wrong. Flush suppresses the check.
    assign w_miss = pop && !flush && (w_empty || (top_addr != jr_target));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mispredict <= 1'b0;
            r_mcnt       <= '0;
        end else begin
            r_mispredict <= w_miss;
            if (w_miss && (r_mcnt != '1)) begin
                r_mcnt <= r_mcnt + 1'b1;
            end
        end
    end

    assign mispredict     = r_mispredict;
    assign mispredict_cnt = r_mcnt;
`else
    logic w_unused_jr;
    assign w_unused_jr    = ^jr_target;
    assign mispredict     = 1'b0;
    assign mispredict_cnt = '0;
`endif

endmodule
